// File: rtl/unidade_controle_if.sv
// Control/status bundle between the accumulator CPU controller and its datapath,
// memory port and I/O port.
interface unidade_controle_if;
  logic [15:0] operacao;
  logic [3:0]  modo;
  logic        flag_n;
  logic        flag_z;
  logic        mem_ack;
  logic        in_valid;
  logic        out_ready;

  logic [1:0]  sel_end;
  logic        carga_rem;
  logic        carga_ri;
  logic        carga_rdm;
  logic        carga_ac;
  logic        carga_pc;
  logic        inc_pc;
  logic [1:0]  sel_ac;
  logic [2:0]  ula_op;
  logic        mem_req;
  logic        mem_we;
  logic        in_req;
  logic        out_valid;
  logic        parado;
  logic        erro;
  logic [3:0]  estado;

  modport master (
    input  operacao, modo, flag_n, flag_z, mem_ack, in_valid, out_ready,
    output sel_end, carga_rem, carga_ri, carga_rdm, carga_ac, carga_pc, inc_pc,
           sel_ac, ula_op, mem_req, mem_we, in_req, out_valid, parado, erro, estado
  );

  modport slave (
    output operacao, modo, flag_n, flag_z, mem_ack, in_valid, out_ready,
    input  sel_end, carga_rem, carga_ri, carga_rdm, carga_ac, carga_pc, inc_pc,
           sel_ac, ula_op, mem_req, mem_we, in_req, out_valid, parado, erro, estado
  );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle control FSM of the 16-bit accumulator CPU: fetch, addressing,
// execute and write-back over a single memory port, with memory-wait timeout.
module unidade_controle #(
  parameter int unsigned TIMEOUT_CICLOS = 16
) (
  input logic                clk,
  input logic                rst_n,
  unidade_controle_if.master bus
);
  typedef enum logic [3:0] {
    BUSCA_END  = 4'd0,
    BUSCA_ESP  = 4'd1,
    CARGA_RI   = 4'd2,
    DECODIFICA = 4'd3,
    IND_END    = 4'd4,
    IND_ESP    = 4'd5,
    OPER_END   = 4'd6,
    OPER_ESP   = 4'd7,
    EXECUTA    = 4'd8,
    ESCREVE    = 4'd9,
    ESPERA_IO  = 4'd10,
    PARADO     = 4'd11,
    ERRO       = 4'd12
  } estado_t;

  localparam int unsigned B_NOP = 15, B_STA = 14, B_LDA = 13, B_ADD = 12, B_SUB = 11;
  localparam int unsigned B_AND = 10, B_OR = 9, B_NOT = 8, B_J = 7, B_JN = 6, B_JZ = 5;
  localparam int unsigned B_IN = 4, B_OUT = 3, B_SHR = 2, B_SHL = 1, B_HLT = 0;
  localparam int unsigned M_DIR = 3, M_IND = 2, M_IM = 1, M_SOP = 0;
  localparam logic [15:0] USA_MODO = 16'h7EE0;
  localparam logic [15:0] SALTOS   = 16'h00E0;
  localparam logic [15:0] COM_IO   = 16'h0018;
  localparam logic [7:0]  LIMITE   = 8'(TIMEOUT_CICLOS - 1);

  estado_t     estado_q, estado_d;
  logic [7:0]  espera_q, espera_d;
  logic [15:0] op;
  logic [3:0]  md;
  logic        em_espera, esgotou, ilegal;

  logic [1:0]  sel_end, sel_ac;
  logic [2:0]  ula_op;
  logic        carga_rem, carga_ri, carga_rdm, carga_ac, carga_pc, inc_pc;
  logic        mem_req, mem_we, in_req, out_valid, parado, erro;

  assign op = bus.operacao;
  assign md = bus.modo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= BUSCA_END;
      espera_q <= '0;
    end else begin
      estado_q <= estado_d;
      espera_q <= espera_d;
    end
  end

  always_comb begin
    em_espera = estado_q inside {BUSCA_ESP, IND_ESP, OPER_ESP, ESCREVE};
    esgotou   = em_espera && !bus.mem_ack && (espera_q == LIMITE);
    // counter restarts whenever a wait ends, so every wait state is entered with zero
    espera_d  = (em_espera && !bus.mem_ack) ? espera_q + 8'd1 : '0;
    ilegal    = !$onehot(op) || !$onehot(md) || (op[B_STA] && md[M_IM]) ||
                ((|(op & USA_MODO)) && md[M_SOP]);
    estado_d  = estado_q;
    case (estado_q)
      BUSCA_END:  estado_d = BUSCA_ESP;
      BUSCA_ESP:  if (bus.mem_ack) estado_d = CARGA_RI; else if (esgotou) estado_d = ERRO;
      CARGA_RI:   estado_d = DECODIFICA;
      DECODIFICA: begin
        if (ilegal)                 estado_d = ERRO;
        else if (op[B_NOP])         estado_d = BUSCA_END;
        else if (op[B_HLT])         estado_d = PARADO;
        else if (!(|(op & USA_MODO)) || md[M_IM]) estado_d = EXECUTA;
        else if (md[M_IND])         estado_d = IND_END;
        else                        estado_d = OPER_END;
      end
      IND_END:    estado_d = IND_ESP;
      IND_ESP:    if (bus.mem_ack) estado_d = OPER_END; else if (esgotou) estado_d = ERRO;
      OPER_END: begin
        if (|(op & SALTOS))  estado_d = EXECUTA;
        else if (op[B_STA])  estado_d = ESCREVE;
        else                 estado_d = OPER_ESP;
      end
      OPER_ESP:   if (bus.mem_ack) estado_d = EXECUTA; else if (esgotou) estado_d = ERRO;
      EXECUTA:    estado_d = (|(op & COM_IO)) ? ESPERA_IO : BUSCA_END;
      ESCREVE:    if (bus.mem_ack) estado_d = BUSCA_END; else if (esgotou) estado_d = ERRO;
      ESPERA_IO: begin
        if ((op[B_IN] && bus.in_valid) || (op[B_OUT] && bus.out_ready)) estado_d = BUSCA_END;
      end
      PARADO:     estado_d = PARADO;
      ERRO:       estado_d = ERRO;
      default:    estado_d = ERRO;
    endcase
  end

  // Outputs are gated by rst_n so they drop to zero as soon as reset asserts.
  always_comb begin
    sel_end = '0; sel_ac = '0; ula_op = '0;
    carga_rem = 1'b0; carga_ri = 1'b0; carga_rdm = 1'b0; carga_ac = 1'b0;
    carga_pc = 1'b0; inc_pc = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    in_req = 1'b0; out_valid = 1'b0; parado = 1'b0; erro = 1'b0;
    if (rst_n) begin
      case (estado_q)
        BUSCA_END: carga_rem = 1'b1;
        BUSCA_ESP: begin
          mem_req   = 1'b1;
          carga_rdm = bus.mem_ack;
          inc_pc    = bus.mem_ack;
        end
        CARGA_RI:  carga_ri = 1'b1;
        IND_END: begin
          sel_end   = 2'b01;
          carga_rem = 1'b1;
        end
        IND_ESP, OPER_ESP: begin
          mem_req   = 1'b1;
          carga_rdm = bus.mem_ack;
        end
        OPER_END: begin
          sel_end   = md[M_IND] ? 2'b10 : 2'b01;
          carga_rem = 1'b1;
        end
        EXECUTA: begin
          case (1'b1)
            op[B_LDA]: begin sel_ac = md[M_IM] ? 2'b10 : 2'b01; carga_ac = 1'b1; end
            op[B_ADD]: begin ula_op = 3'd0; carga_ac = 1'b1; end
            op[B_SUB]: begin ula_op = 3'd1; carga_ac = 1'b1; end
            op[B_AND]: begin ula_op = 3'd2; carga_ac = 1'b1; end
            op[B_OR]:  begin ula_op = 3'd3; carga_ac = 1'b1; end
            op[B_NOT]: begin ula_op = 3'd4; carga_ac = 1'b1; end
            op[B_SHR]: begin ula_op = 3'd5; carga_ac = 1'b1; end
            op[B_SHL]: begin ula_op = 3'd6; carga_ac = 1'b1; end
            op[B_J]:   carga_pc = 1'b1;
            op[B_JN]:  carga_pc = bus.flag_n;
            op[B_JZ]:  carga_pc = bus.flag_z;
            default:   ;
          endcase
        end
        ESCREVE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        ESPERA_IO: begin
          if (op[B_IN]) begin
            in_req = 1'b1;
            if (bus.in_valid) begin
              sel_ac   = 2'b11;
              carga_ac = 1'b1;
            end
          end else begin
            out_valid = 1'b1;
          end
        end
        PARADO:  parado = 1'b1;
        ERRO:    erro = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.sel_end   = sel_end;
  assign bus.carga_rem = carga_rem;
  assign bus.carga_ri  = carga_ri;
  assign bus.carga_rdm = carga_rdm;
  assign bus.carga_ac  = carga_ac;
  assign bus.carga_pc  = carga_pc;
  assign bus.inc_pc    = inc_pc;
  assign bus.sel_ac    = sel_ac;
  assign bus.ula_op    = ula_op;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.in_req    = in_req;
  assign bus.out_valid = out_valid;
  assign bus.parado    = parado;
  assign bus.erro      = erro;
  assign bus.estado    = estado_q;
endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: each instruction is expanded into an expected
// per-cycle trace from the instruction-level rules, then replayed against the DUT.
module tb_unidade_controle;
  localparam int unsigned TO = 16;
  localparam int I_NOP = 15, I_STA = 14, I_LDA = 13, I_ADD = 12, I_SUB = 11, I_AND = 10;
  localparam int I_OR = 9, I_NOT = 8, I_J = 7, I_JN = 6, I_JZ = 5, I_IN = 4, I_OUT = 3;
  localparam int I_SHR = 2, I_SHL = 1, I_HLT = 0;
  localparam int M_DIR = 3, M_IND = 2, M_IM = 1, M_SOP = 0;
  localparam int E_BUSCA_END = 0, E_BUSCA_ESP = 1, E_CARGA_RI = 2, E_DECOD = 3;
  localparam int E_IND_END = 4, E_IND_ESP = 5, E_OPER_END = 6, E_OPER_ESP = 7;
  localparam int E_EXECUTA = 8, E_ESCREVE = 9, E_ESPERA_IO = 10, E_PARADO = 11, E_ERRO = 12;

  typedef struct packed {
    logic [3:0] est;
    logic [1:0] sel_end;
    logic       rem, ri, rdm, ac, pc, inc;
    logic [1:0] sel_ac;
    logic [2:0] ula;
    logic       req, we, inreq, outv, parado, erro;
    logic       ack, inv, outr;
  } passo_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   fn, fz;
  int     erros = 0;
  int     total = 0;
  passo_t roteiro[$];

  always #5 clk = ~clk;

  unidade_controle_if bus();

  unidade_controle #(.TIMEOUT_CICLOS(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, esp);
    end
  endtask

  function automatic logic [22:0] esperado(passo_t p);
    return {p.est, p.sel_end, p.rem, p.ri, p.rdm, p.ac, p.pc, p.inc, p.sel_ac, p.ula,
            p.req, p.we, p.inreq, p.outv, p.parado, p.erro};
  endfunction

  function automatic logic [22:0] observado();
    return {bus.estado, bus.sel_end, bus.carga_rem, bus.carga_ri, bus.carga_rdm, bus.carga_ac,
            bus.carga_pc, bus.inc_pc, bus.sel_ac, bus.ula_op, bus.mem_req, bus.mem_we,
            bus.in_req, bus.out_valid, bus.parado, bus.erro};
  endfunction

  function automatic passo_t novo(input int e);
    passo_t p;
    p      = '0;
    p.est  = 4'(e);
    p.ack  = ($urandom_range(0, 3) == 0);
    p.inv  = 1'($urandom_range(0, 1));
    p.outr = 1'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic bit usa_modo(input int k);
    return k inside {I_STA, I_LDA, I_ADD, I_SUB, I_AND, I_OR, I_J, I_JN, I_JZ};
  endfunction

  function automatic logic [2:0] ula_de(input int k);
    case (k)
      I_SUB:   return 3'd1;
      I_AND:   return 3'd2;
      I_OR:    return 3'd3;
      I_NOT:   return 3'd4;
      I_SHR:   return 3'd5;
      I_SHL:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [15:0] op, input logic [3:0] md);
    int k;
    k = 0;
    if ($countones(op) != 1 || $countones(md) != 1) return 1'b0;
    for (int i = 0; i < 16; i++) if (op[i]) k = i;
    if (k == I_STA && (md[M_IM] || md[M_SOP])) return 1'b0;
    if (usa_modo(k) && md[M_SOP]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic absorve(input int e);
    passo_t p;
    for (int i = 0; i < 4; i++) begin
      p = novo(e);
      p.parado = (e == E_PARADO);
      p.erro   = (e == E_ERRO);
      roteiro.push_back(p);
    end
  endtask

  task automatic espera_mem(input int e, input int atraso, input bit rdm, input bit inc,
                            input bit we, output bit estourou);
    passo_t p;
    int     n;
    estourou = (atraso >= int'(TO));
    n = estourou ? int'(TO) : atraso;
    for (int i = 0; i < n; i++) begin
      p = novo(e); p.req = 1'b1; p.we = we; p.ack = 1'b0;
      roteiro.push_back(p);
    end
    if (!estourou) begin
      p = novo(e); p.req = 1'b1; p.we = we; p.ack = 1'b1; p.rdm = rdm; p.inc = inc;
      roteiro.push_back(p);
    end
  endtask

  task automatic monta(input logic [15:0] op, input logic [3:0] md,
                       input int d0, input int d1, input int d2, input int dio);
    passo_t p;
    bit     to;
    int     k;
    k = 0;
    for (int i = 0; i < 16; i++) if (op[i]) k = i;
    p = novo(E_BUSCA_END); p.rem = 1'b1; roteiro.push_back(p);
    espera_mem(E_BUSCA_ESP, d0, 1'b1, 1'b1, 1'b0, to);
    if (to) begin absorve(E_ERRO); return; end
    p = novo(E_CARGA_RI); p.ri = 1'b1; roteiro.push_back(p);
    p = novo(E_DECOD); roteiro.push_back(p);
    if (!legal(op, md)) begin absorve(E_ERRO); return; end
    if (k == I_NOP) return;
    if (k == I_HLT) begin absorve(E_PARADO); return; end
    if (usa_modo(k) && md[M_IND]) begin
      p = novo(E_IND_END); p.sel_end = 2'b01; p.rem = 1'b1; roteiro.push_back(p);
      espera_mem(E_IND_ESP, d1, 1'b1, 1'b0, 1'b0, to);
      if (to) begin absorve(E_ERRO); return; end
    end
    if (usa_modo(k) && (md[M_IND] || md[M_DIR])) begin
      p = novo(E_OPER_END); p.sel_end = md[M_IND] ? 2'b10 : 2'b01; p.rem = 1'b1;
      roteiro.push_back(p);
      if (k == I_STA) begin
        espera_mem(E_ESCREVE, d2, 1'b0, 1'b0, 1'b1, to);
        if (to) absorve(E_ERRO);
        return;
      end
      if (!(k inside {I_J, I_JN, I_JZ})) begin
        espera_mem(E_OPER_ESP, d2, 1'b1, 1'b0, 1'b0, to);
        if (to) begin absorve(E_ERRO); return; end
      end
    end
    p = novo(E_EXECUTA);
    case (k)
      I_LDA: begin p.sel_ac = md[M_IM] ? 2'b10 : 2'b01; p.ac = 1'b1; end
      I_ADD, I_SUB, I_AND, I_OR, I_NOT, I_SHR, I_SHL: begin p.ula = ula_de(k); p.ac = 1'b1; end
      I_J:     p.pc = 1'b1;
      I_JN:    p.pc = fn;
      I_JZ:    p.pc = fz;
      default: ;
    endcase
    roteiro.push_back(p);
    if (k == I_IN || k == I_OUT) begin
      for (int i = 0; i <= dio; i++) begin
        p = novo(E_ESPERA_IO);
        if (k == I_IN) begin
          p.inreq = 1'b1; p.inv = (i == dio);
          if (i == dio) begin p.sel_ac = 2'b11; p.ac = 1'b1; end
        end else begin
          p.outv = 1'b1; p.outr = (i == dio);
        end
        roteiro.push_back(p);
      end
    end
  endtask

  task automatic executa(input int maximo);
    passo_t p;
    int     n;
    n = 0;
    while (roteiro.size() > 0 && n < maximo) begin
      p = roteiro.pop_front();
      bus.mem_ack = p.ack; bus.in_valid = p.inv; bus.out_ready = p.outr;
      bus.flag_n = fn; bus.flag_z = fz;
      #1;
      confere($sformatf("step%0d estado=%0d", n, p.est), 32'(observado()), 32'(esperado(p)));
      @(negedge clk);
      n++;
    end
  endtask

  task automatic instr(input int k, input int m, input int d0, input int d1, input int d2,
                       input int dio);
    logic [15:0] op;
    logic [3:0]  md;
    op = '0; md = '0;
    if (k >= 0) op[k] = 1'b1;
    if (m >= 0) md[m] = 1'b1;
    bus.operacao = op; bus.modo = md;
    monta(op, md, d0, d1, d2, dio);
    executa(100000);
  endtask

  task automatic reinicia();
    rst_n = 1'b0;
    bus.mem_ack = 1'b1;
    #1 confere("reset_async", 32'(observado()), 32'd0);
    @(posedge clk);
    #1 confere("reset_held", 32'(observado()), 32'd0);
    roteiro.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k, m;
    rst_n = 1'b0; fn = 1'b0; fz = 1'b0;
    bus.operacao = '0; bus.modo = '0; bus.flag_n = 1'b0; bus.flag_z = 1'b0;
    bus.mem_ack = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    reinicia();

    instr(I_LDA, M_IM, 0, 0, 0, 0);
    instr(I_ADD, M_IND, 0, 0, 0, 0);
    fz = 1'b0; instr(I_JZ, M_DIR, 0, 0, 0, 0);
    fz = 1'b1; instr(I_JZ, M_DIR, 1, 0, 0, 0);
    fn = 1'b1; instr(I_JN, M_IND, 0, 2, 0, 0);
    instr(I_STA, M_DIR, 0, 0, 3, 0);
    instr(I_STA, M_IND, 2, 1, 15, 0);
    instr(I_NOP, M_SOP, 0, 0, 0, 0);
    instr(I_IN, M_SOP, 0, 0, 0, 3);
    instr(I_OUT, M_DIR, 0, 0, 0, 2);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(1, 15);
      m = $urandom_range(0, 3);
      if (k == I_STA && (m == M_IM || m == M_SOP)) m = M_DIR;
      if (usa_modo(k) && m == M_SOP) m = M_IND;
      fn = 1'($urandom_range(0, 1));
      fz = 1'($urandom_range(0, 1));
      instr(k, m,
            ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
            $urandom_range(0, 3));
    end

    // reset while OPER_ESP is still waiting for its operand
    bus.operacao = 16'h0000; bus.operacao[I_ADD] = 1'b1;
    bus.modo = 4'h0; bus.modo[M_DIR] = 1'b1;
    monta(bus.operacao, bus.modo, 0, 0, 5, 0);
    executa(8);
    reinicia();
    instr(I_LDA, M_IM, 0, 0, 0, 0);

    instr(I_STA, M_DIR, 0, 0, 16, 0);
    reinicia();
    instr(I_LDA, M_DIR, 16, 0, 0, 0);
    reinicia();
    instr(-1, M_DIR, 0, 0, 0, 0);
    reinicia();
    instr(I_STA, M_IM, 0, 0, 0, 0);
    reinicia();
    instr(I_ADD, M_SOP, 0, 0, 0, 0);
    reinicia();
    instr(I_ADD, -1, 0, 0, 0, 0);
    reinicia();
    instr(I_HLT, M_DIR, 0, 0, 0, 0);
    reinicia();
    instr(I_SUB, M_IM, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", erros, total);
    $finish;
  end
endmodule
